// File: rtl/img_rsz_frm_arb_if.sv
// ---------------------------------------------------------------------------
// img_rsz_frm_arb_if
// Bundle of every non-clock, non-reset signal of the frame arbiter.
//   Src*          : per-source pixel streams, flattened (source i at [i*W +: W])
//   SrcPxlRdy     : per-source ready back to the sources
//   Pxl*/Img*     : muxed stream and latched frame size towards the resizer
//   PxlRdy        : ready from the resizer
//   RszImgComp    : resizer finished the current frame (1-cycle pulse)
//   GntIdx/Busy/ArbErr : status
// Modports:
//   master : the arbiter itself (drives readies, muxed stream and status)
//   slave  : the surroundings (sources plus resizer)
// ---------------------------------------------------------------------------
interface img_rsz_frm_arb_if #(
    parameter int SRC_NUM          = 4,
    parameter int IMG_WIDTH_IDX_W  = 11,
    parameter int IMG_HEIGHT_IDX_W = 11,
    parameter int PXL_W            = 24,
    parameter int SRC_IDX_W        = $clog2(SRC_NUM)
);
    logic [SRC_NUM*PXL_W-1:0]            SrcPxlData;
    logic [SRC_NUM*IMG_WIDTH_IDX_W-1:0]  SrcPxlX;
    logic [SRC_NUM*IMG_HEIGHT_IDX_W-1:0] SrcPxlY;
    logic [SRC_NUM*IMG_WIDTH_IDX_W-1:0]  SrcImgWidth;
    logic [SRC_NUM*IMG_HEIGHT_IDX_W-1:0] SrcImgHeight;
    logic [SRC_NUM-1:0]                  SrcPxlVld;
    logic [SRC_NUM-1:0]                  SrcPxlRdy;
    logic [PXL_W-1:0]                    PxlData;
    logic [IMG_WIDTH_IDX_W-1:0]          PxlX;
    logic [IMG_HEIGHT_IDX_W-1:0]         PxlY;
    logic [IMG_WIDTH_IDX_W-1:0]          ImgWidth;
    logic [IMG_HEIGHT_IDX_W-1:0]         ImgHeight;
    logic                                PxlVld;
    logic                                PxlRdy;
    logic                                RszImgComp;
    logic [SRC_IDX_W-1:0]                GntIdx;
    logic                                Busy;
    logic                                ArbErr;

    modport master (
        input  SrcPxlData, SrcPxlX, SrcPxlY, SrcImgWidth, SrcImgHeight, SrcPxlVld,
        output SrcPxlRdy,
        output PxlData, PxlX, PxlY, ImgWidth, ImgHeight, PxlVld,
        input  PxlRdy, RszImgComp,
        output GntIdx, Busy, ArbErr
    );

    modport slave (
        output SrcPxlData, SrcPxlX, SrcPxlY, SrcImgWidth, SrcImgHeight, SrcPxlVld,
        input  SrcPxlRdy,
        input  PxlData, PxlX, PxlY, ImgWidth, ImgHeight, PxlVld,
        output PxlRdy, RszImgComp,
        input  GntIdx, Busy, ArbErr
    );
endinterface

// File: rtl/img_rsz_frm_arb.sv
// ---------------------------------------------------------------------------
// img_rsz_frm_arb
// Frame-granular arbiter sharing one resizer pixel path between SRC_NUM
// sources. A source is granted for a whole frame; its stream is muxed
// combinationally onto the resizer input and its frame size is latched at
// grant time. After the last pixel handshake the arbiter waits for the
// resizer's RszImgComp before picking the next source.
// Ports:
//   Clk    : clock
//   Reset  : asynchronous, active-high reset
//   bus    : img_rsz_frm_arb_if.master (sources, resizer side, status)
// Build option:
//   IMG_RSZ_ARB_STRICT_PRIO_EN : fixed priority (lowest index wins) instead of
//                                round-robin; no rotating pointer exists then.
// ---------------------------------------------------------------------------
module img_rsz_frm_arb #(
    parameter int SRC_NUM          = 4,
    parameter int IMG_WIDTH_IDX_W  = 11,
    parameter int IMG_HEIGHT_IDX_W = 11,
    parameter int PXL_W            = 24,
    parameter int SRC_IDX_W        = $clog2(SRC_NUM)
) (
    input logic             Clk,
    input logic             Reset,
    img_rsz_frm_arb_if.master bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_DRAIN} state_t;

    state_t                      state_q, state_d;
    logic [SRC_IDX_W-1:0]        gnt_idx_q, gnt_idx_d;
    logic [IMG_WIDTH_IDX_W-1:0]  img_width_q, img_width_d;
    logic [IMG_HEIGHT_IDX_W-1:0] img_height_q, img_height_d;
    logic [IMG_WIDTH_IDX_W-1:0]  hor_cnt_q, hor_cnt_d;
    logic [IMG_HEIGHT_IDX_W-1:0] ver_cnt_q, ver_cnt_d;
    logic                        arb_err_q, arb_err_d;
`ifndef IMG_RSZ_ARB_STRICT_PRIO_EN
    logic [SRC_IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
`endif

    // Unflattened per-source views, indexable by the grant index.
    logic [PXL_W-1:0]            src_data [SRC_NUM];
    logic [IMG_WIDTH_IDX_W-1:0]  src_x    [SRC_NUM];
    logic [IMG_HEIGHT_IDX_W-1:0] src_y    [SRC_NUM];
    logic [IMG_WIDTH_IDX_W-1:0]  src_w    [SRC_NUM];
    logic [IMG_HEIGHT_IDX_W-1:0] src_h    [SRC_NUM];

    generate
        for (genvar gi = 0; gi < SRC_NUM; gi++) begin : g_unpack
            assign src_data[gi] = bus.SrcPxlData[gi*PXL_W +: PXL_W];
            assign src_x[gi]    = bus.SrcPxlX[gi*IMG_WIDTH_IDX_W +: IMG_WIDTH_IDX_W];
            assign src_y[gi]    = bus.SrcPxlY[gi*IMG_HEIGHT_IDX_W +: IMG_HEIGHT_IDX_W];
            assign src_w[gi]    = bus.SrcImgWidth[gi*IMG_WIDTH_IDX_W +: IMG_WIDTH_IDX_W];
            assign src_h[gi]    = bus.SrcImgHeight[gi*IMG_HEIGHT_IDX_W +: IMG_HEIGHT_IDX_W];
        end
    endgenerate

    // Winner search. Offsets are scanned from the far end so that the
    // nearest requester to the start point is the one left in win_idx.
    logic                 win_found;
    logic [SRC_IDX_W-1:0] win_idx;
    logic [SRC_IDX_W:0]   cand_sum;
    logic [SRC_IDX_W-1:0] cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = SRC_NUM - 1; k >= 0; k--) begin
`ifdef IMG_RSZ_ARB_STRICT_PRIO_EN
            cand_sum = (SRC_IDX_W+1)'(k);
`else
            cand_sum = {1'b0, rr_ptr_q} + (SRC_IDX_W+1)'(k);
            if (cand_sum >= (SRC_IDX_W+1)'(SRC_NUM)) begin
                cand_sum = cand_sum - (SRC_IDX_W+1)'(SRC_NUM);
            end
`endif
            cand = cand_sum[SRC_IDX_W-1:0];
            if (bus.SrcPxlVld[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    logic [SRC_NUM-1:0] src_rdy;
    logic               pxl_vld;
    logic               last_pxl;
    logic               hor_last;

    assign hor_last = (hor_cnt_q == img_width_q - IMG_WIDTH_IDX_W'(1));
    assign last_pxl = hor_last && (ver_cnt_q == img_height_q - IMG_HEIGHT_IDX_W'(1));

    always_comb begin
        state_d      = state_q;
        gnt_idx_d    = gnt_idx_q;
        img_width_d  = img_width_q;
        img_height_d = img_height_q;
        hor_cnt_d    = hor_cnt_q;
        ver_cnt_d    = ver_cnt_q;
`ifndef IMG_RSZ_ARB_STRICT_PRIO_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        // A completion is only legitimate while draining; the last-pixel
        // cycle itself is still GRANT and therefore also flagged.
        arb_err_d    = bus.RszImgComp && (state_q != ST_DRAIN);
        pxl_vld      = 1'b0;
        src_rdy      = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d      = ST_GRANT;
                    gnt_idx_d    = win_idx;
                    img_width_d  = src_w[win_idx];
                    img_height_d = src_h[win_idx];
                    hor_cnt_d    = '0;
                    ver_cnt_d    = '0;
`ifndef IMG_RSZ_ARB_STRICT_PRIO_EN
                    if (win_idx == SRC_IDX_W'(SRC_NUM - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = win_idx + SRC_IDX_W'(1);
                    end
`endif
                end
            end
            ST_GRANT: begin
                pxl_vld            = bus.SrcPxlVld[gnt_idx_q];
                src_rdy[gnt_idx_q] = bus.PxlRdy;
                if (pxl_vld && bus.PxlRdy) begin
                    if (last_pxl) begin
                        state_d = ST_DRAIN;
                    end
                    if (hor_last) begin
                        hor_cnt_d = '0;
                        ver_cnt_d = ver_cnt_q + IMG_HEIGHT_IDX_W'(1);
                    end else begin
                        hor_cnt_d = hor_cnt_q + IMG_WIDTH_IDX_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.RszImgComp) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            gnt_idx_q    <= '0;
            img_width_q  <= '1;
            img_height_q <= '1;
            hor_cnt_q    <= '0;
            ver_cnt_q    <= '0;
            arb_err_q    <= 1'b0;
`ifndef IMG_RSZ_ARB_STRICT_PRIO_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_idx_q    <= gnt_idx_d;
            img_width_q  <= img_width_d;
            img_height_q <= img_height_d;
            hor_cnt_q    <= hor_cnt_d;
            ver_cnt_q    <= ver_cnt_d;
            arb_err_q    <= arb_err_d;
`ifndef IMG_RSZ_ARB_STRICT_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    // Stream outputs decode from the current state, so an asynchronous reset
    // drops them in the same cycle.
    assign bus.SrcPxlRdy = src_rdy;
    assign bus.PxlVld    = pxl_vld;
    assign bus.PxlData   = src_data[gnt_idx_q];
    assign bus.PxlX      = src_x[gnt_idx_q];
    assign bus.PxlY      = src_y[gnt_idx_q];
    assign bus.ImgWidth  = img_width_q;
    assign bus.ImgHeight = img_height_q;
    assign bus.GntIdx    = gnt_idx_q;
    assign bus.Busy      = (state_q != ST_IDLE);
    assign bus.ArbErr    = arb_err_q;
endmodule

// File: tb/tb_img_rsz_frm_arb.sv
// ---------------------------------------------------------------------------
// tb_img_rsz_frm_arb
// Randomized sources and resizer around img_rsz_frm_arb. A frame-level model
// (granted source, pixels accepted vs width*height, draining flag) predicts
// every output each cycle; directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_img_rsz_frm_arb;
    localparam int N  = 4;
    localparam int WW = 11;
    localparam int HW = 11;
    localparam int PW = 24;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    img_rsz_frm_arb_if #(.SRC_NUM(N), .IMG_WIDTH_IDX_W(WW), .IMG_HEIGHT_IDX_W(HW),
                         .PXL_W(PW), .SRC_IDX_W(IW)) bus ();

    img_rsz_frm_arb #(.SRC_NUM(N), .IMG_WIDTH_IDX_W(WW), .IMG_HEIGHT_IDX_W(HW),
                      .PXL_W(PW), .SRC_IDX_W(IW)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- source / resizer stimulus state ----------------
    int          fw [N], fh [N], px [N], py [N], frames_left [N], hs_cnt [N];
    logic [PW-1:0] sdata [N];
    bit          svld [N];
    int          vld_pct, rdy_mode, exp_pix;
    bit          comp_auto, comp_spur, rand_size;

    // ---------------- frame-level model ----------------
    bit m_busy, m_drain, m_err;
    int m_gnt, m_w, m_h, m_done, m_start;
    int gl [256];
    int gl_n = 0;

    task automatic model_reset();
        m_busy = 0; m_drain = 0; m_err = 0;
        m_gnt = 0; m_w = (1 << WW) - 1; m_h = (1 << HW) - 1;
        m_done = 0; m_start = 0;
    endtask

    // Compare + advance at the falling edge: inputs are stable here and the
    // model's next values describe the state after the coming rising edge.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        bit           exp_vld, err_n;
        int           c;
        if (rst) model_reset();
        exp_vld = m_busy && !m_drain && bus.SrcPxlVld[m_gnt];
        exp_rdy = (m_busy && !m_drain && bus.PxlRdy) ? (N'(1) << m_gnt) : '0;
        chk("PxlVld",    longint'(bus.PxlVld),    longint'(exp_vld));
        chk("SrcPxlRdy", longint'(bus.SrcPxlRdy), longint'(exp_rdy));
        chk("Busy",      longint'(bus.Busy),      longint'(m_busy));
        chk("GntIdx",    longint'(bus.GntIdx),    longint'(m_gnt));
        chk("ImgWidth",  longint'(bus.ImgWidth),  longint'(m_w));
        chk("ImgHeight", longint'(bus.ImgHeight), longint'(m_h));
        chk("ArbErr",    longint'(bus.ArbErr),    longint'(m_err));
        if (exp_vld) begin
            chk("PxlData", longint'(bus.PxlData), longint'(bus.SrcPxlData[m_gnt*PW +: PW]));
            chk("PxlX",    longint'(bus.PxlX),    longint'(bus.SrcPxlX[m_gnt*WW +: WW]));
            chk("PxlY",    longint'(bus.PxlY),    longint'(bus.SrcPxlY[m_gnt*HW +: HW]));
        end
        if (!rst) begin
            err_n = bus.RszImgComp && !(m_busy && m_drain);
            if (!m_busy) begin
                if (|bus.SrcPxlVld) begin
                    for (int k = N - 1; k >= 0; k--) begin
`ifdef IMG_RSZ_ARB_STRICT_PRIO_EN
                        c = k;
`else
                        c = (m_start + k) % N;
`endif
                        if (bus.SrcPxlVld[c]) m_gnt = c;
                    end
                    m_start = (m_gnt + 1) % N;
                    m_w     = int'(bus.SrcImgWidth[m_gnt*WW +: WW]);
                    m_h     = int'(bus.SrcImgHeight[m_gnt*HW +: HW]);
                    m_done  = 0;
                    m_busy  = 1;
                    m_drain = 0;
                    if (gl_n < 256) gl[gl_n] = m_gnt;
                    gl_n++;
                end
            end else if (!m_drain) begin
                if (exp_vld && bus.PxlRdy) begin
                    m_done++;
                    if (m_done == m_w * m_h) m_drain = 1;
                end
            end else if (bus.RszImgComp) begin
                m_busy = 0;
                m_drain = 0;
            end
            m_err = err_n;
        end
    end

    // ---------------- driver ----------------
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.SrcPxlData[i*PW +: PW]   = sdata[i];
            bus.SrcPxlX[i*WW +: WW]      = WW'(px[i]);
            bus.SrcPxlY[i*HW +: HW]      = HW'(py[i]);
            bus.SrcImgWidth[i*WW +: WW]  = WW'(fw[i]);
            bus.SrcImgHeight[i*HW +: HW] = HW'(fh[i]);
            bus.SrcPxlVld[i]             = svld[i];
        end
    endtask

    task automatic set_src(input int i, input int w, input int h, input int frames);
        fw[i] = w; fh[i] = h; px[i] = 0; py[i] = 0;
        frames_left[i] = frames;
        if (frames > 0) exp_pix += w * h;
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < N; i++) begin
            set_src(i, 1, 1, 0);
            hs_cnt[i] = 0;
            svld[i] = 0;
        end
        exp_pix = 0;
    endtask

    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = bus.SrcPxlVld & bus.SrcPxlRdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                hs_cnt[i]++;
                if (px[i] == fw[i] - 1) begin
                    px[i] = 0;
                    if (py[i] == fh[i] - 1) begin
                        py[i] = 0;
                        frames_left[i]--;
                        if (rand_size && frames_left[i] > 0) begin
                            fw[i] = $urandom_range(4, 1);
                            fh[i] = $urandom_range(3, 1);
                        end
                        if (frames_left[i] > 0) exp_pix += fw[i] * fh[i];
                    end else begin
                        py[i]++;
                    end
                end else begin
                    px[i]++;
                end
                sdata[i] = PW'($urandom);
            end
            svld[i] = (frames_left[i] > 0) && ($urandom_range(99) < vld_pct);
        end
        case (rdy_mode)
            1:       bus.PxlRdy = 1'b1;
            2:       bus.PxlRdy = ~bus.PxlRdy;
            default: bus.PxlRdy = ($urandom_range(99) < 60);
        endcase
        if (comp_auto) begin
            if (m_busy && m_drain) bus.RszImgComp = ($urandom_range(2) == 0);
            else                   bus.RszImgComp = comp_spur && ($urandom_range(24) == 0);
        end else begin
            bus.RszImgComp = 1'b0;
        end
        drive();
    endtask

    function automatic bit all_done();
        bit d = !m_busy;
        for (int i = 0; i < N; i++) if (frames_left[i] != 0) d = 0;
        return d;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        clear_srcs();
        step();
        step();
        rst = 1'b0;
    endtask

    int exp_order [5];
    int base, tot;

    initial begin
`ifdef IMG_RSZ_ARB_STRICT_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        vld_pct = 100; rdy_mode = 1; comp_auto = 0; comp_spur = 0; rand_size = 0;
        bus.PxlRdy = 1'b0;
        bus.RszImgComp = 1'b0;
        for (int i = 0; i < N; i++) sdata[i] = PW'($urandom);
        clear_srcs();
        drive();
        do_reset();
        chk("rst_imgw", longint'(bus.ImgWidth), 64'h7ff);
        chk("rst_busy", longint'(bus.Busy), 0);

        // Single source 4x2, always ready.
        set_src(1, 4, 2, 1);
        for (int c = 0; c < 200 && hs_cnt[1] < 8; c++) step();
        chk("t1_hs", hs_cnt[1], 8);
        chk("t1_busy_drain", longint'(bus.Busy), 1);
        chk("t1_vld_drain", longint'(bus.PxlVld), 0);
        step();
        chk("t1_hs_hold", hs_cnt[1], 8);
        bus.RszImgComp = 1'b1;
        step();
        chk("t1_idle", longint'(bus.Busy), 0);

        // All four requesting, 2x2 frames: grant order.
        do_reset();
        comp_auto = 1;
        for (int i = 0; i < N; i++) set_src(i, 2, 2, 5);
        base = gl_n;
        for (int c = 0; c < 3000 && !all_done(); c++) step();
        chk("t2_done", longint'(all_done()), 1);
        for (int k = 0; k < 5; k++)
            chk($sformatf("t2_order%0d", k),
                (base + k < gl_n && base + k < 256) ? gl[base + k] : -1, exp_order[k]);

        // PxlRdy toggling, src2 3x3.
        clear_srcs();
        rdy_mode = 2;
        set_src(2, 3, 3, 1);
        for (int c = 0; c < 500 && !all_done(); c++) step();
        chk("t3_hs", hs_cnt[2], 9);
        chk("t3_others", hs_cnt[0] + hs_cnt[1] + hs_cnt[3], 0);

        // 1x1 frame with completion in the last-pixel cycle.
        clear_srcs();
        rdy_mode = 1; comp_auto = 0;
        set_src(0, 1, 1, 1);
        for (int c = 0; c < 20 && !m_busy; c++) step();
        bus.RszImgComp = 1'b1;
        step();
        chk("t4_hs", hs_cnt[0], 1);
        chk("t4_err", longint'(bus.ArbErr), 1);
        chk("t4_busy", longint'(bus.Busy), 1);
        step();
        chk("t4_err_clr", longint'(bus.ArbErr), 0);
        chk("t4_still_drain", longint'(bus.Busy), 1);
        bus.RszImgComp = 1'b1;
        step();
        chk("t4_idle", longint'(bus.Busy), 0);

        // Reset at pixel 5 of a 4x4 frame.
        clear_srcs();
        comp_auto = 1;
        set_src(3, 4, 4, 1);
        for (int c = 0; c < 200 && hs_cnt[3] < 5; c++) step();
        chk("t5_pre_vld", longint'(bus.PxlVld), 1);
        rst = 1'b1;
        #1;
        chk("t5_vld", longint'(bus.PxlVld), 0);
        chk("t5_rdy", longint'(bus.SrcPxlRdy), 0);
        do_reset();
        chk("t5_gnt", longint'(bus.GntIdx), 0);
        chk("t5_busy", longint'(bus.Busy), 0);
        set_src(3, 2, 2, 1);
        for (int c = 0; c < 200 && !all_done(); c++) step();
        chk("t5_refrm", hs_cnt[3], 4);

        // Completion pulse while idle.
        clear_srcs();
        comp_auto = 0;
        step();
        bus.RszImgComp = 1'b1;
        step();
        chk("t6_err", longint'(bus.ArbErr), 1);
        chk("t6_busy", longint'(bus.Busy), 0);
        step();
        chk("t6_err_clr", longint'(bus.ArbErr), 0);

        // Randomized rounds.
        for (int r = 0; r < 4; r++) begin
            clear_srcs();
            vld_pct = 70; rdy_mode = 0; comp_auto = 1; comp_spur = 1; rand_size = 1;
            for (int i = 0; i < N; i++)
                set_src(i, $urandom_range(4, 1), $urandom_range(3, 1), $urandom_range(4, 1));
            for (int c = 0; c < 15000 && !all_done(); c++) step();
            chk($sformatf("rnd%0d_done", r), longint'(all_done()), 1);
            tot = 0;
            for (int i = 0; i < N; i++) tot += hs_cnt[i];
            chk($sformatf("rnd%0d_pix", r), tot, exp_pix);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
